// File: rtl/fifo_wr_pacer.sv
// Paced FIFO write burst generator: writes burst_len incrementing words from seed,
// one word per DIV-cycle tick, stalling while the FIFO reports full.
module fifo_wr_pacer #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  parameter int DIV    = 18
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] seed,
  input  logic              full,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_d, busy_d, done_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [CNT_W-1:0]  words_d, stall_d;
  logic              tick, do_wr, do_stall;

  assign tick = (cnt_q == DIV_W'(DIV - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data;
    busy_d    = busy;
    done_d    = 1'b0;
    words_d   = words_written;
    stall_d   = stall_cycles;
    do_wr     = 1'b0;
    do_stall  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            rem_d   = burst_len;
            data_d  = seed;
            cnt_d   = '0;
            words_d = '0;
            stall_d = '0;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            done_d  = 1'b1;
            words_d = '0;
          end
        end
      end
      S_RUN: begin
        if (tick) begin
          if (full) begin
            do_stall = 1'b1;
            state_d  = S_HOLD;
          end else begin
            do_wr = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (full) do_stall = 1'b1;
        else      do_wr    = 1'b1;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The tick edge that detects full is counted as the first stalled cycle.
    if (do_stall && (stall_cycles != '1))
      stall_d = stall_cycles + CNT_W'(1);

    if (do_wr) begin
      wr_en_d   = 1'b1;
      wr_data_d = data_q;
      data_d    = data_q + DATA_W'(1);
      cnt_d     = '0;
      rem_d     = rem_q - CNT_W'(1);
      words_d   = words_written + CNT_W'(1);
      state_d   = (rem_q == CNT_W'(1)) ? S_FINISH : S_RUN;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      data_q        <= '0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
      stall_cycles  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      data_q        <= data_d;
      wr_en         <= wr_en_d;
      wr_data       <= wr_data_d;
      busy          <= busy_d;
      done          <= done_d;
      words_written <= words_d;
      stall_cycles  <= stall_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_pacer.sv
// Directed bench for fifo_wr_pacer: table-driven bursts plus stall, ignore-start,
// reset-abort and stall-saturation sequences.
module tb_fifo_wr_pacer;

  localparam int DIV = 18;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       start, full;
  logic [7:0] burst_len, seed;
  logic       wr_en, busy, done;
  logic [7:0] wr_data, words_written, stall_cycles;

  logic       start2, full2;
  logic [3:0] burst_len2;
  logic [7:0] seed2;
  logic       wr_en2, busy2, done2;
  logic [7:0] wr_data2;
  logic [3:0] words_written2, stall_cycles2;

  int checks = 0;
  int failures = 0;

  fifo_wr_pacer #(.DATA_W(8), .CNT_W(8), .DIV(DIV)) u_dut (
    .clk_in(clk_in), .reset(reset), .start(start), .burst_len(burst_len),
    .seed(seed), .full(full), .wr_en(wr_en), .wr_data(wr_data), .busy(busy),
    .done(done), .words_written(words_written), .stall_cycles(stall_cycles)
  );

  fifo_wr_pacer #(.DATA_W(8), .CNT_W(4), .DIV(DIV)) u_sat (
    .clk_in(clk_in), .reset(reset), .start(start2), .burst_len(burst_len2),
    .seed(seed2), .full(full2), .wr_en(wr_en2), .wr_data(wr_data2), .busy(busy2),
    .done(done2), .words_written(words_written2), .stall_cycles(stall_cycles2)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // A write must never be issued at an edge where full was sampled high.
  logic f_s, f2_s;
  always @(posedge clk_in) begin
    f_s  = full;
    f2_s = full2;
    #1;
    if (wr_en)  chk("no_wr_on_full",  {31'd0, f_s},  32'd0);
    if (wr_en2) chk("no_wr_on_full2", {31'd0, f2_s}, 32'd0);
  end

  typedef struct {
    logic [7:0]      len;
    logic [7:0]      sd;
    logic [2:0][7:0] d;
  } vec_t;

  vec_t vecs[4];
  logic saw_done;

  initial begin
    vecs[0] = '{8'd3, 8'h10, {8'h12, 8'h11, 8'h10}};
    vecs[1] = '{8'd3, 8'hFE, {8'h00, 8'hFF, 8'hFE}};
    vecs[2] = '{8'd1, 8'h7F, {8'h00, 8'h00, 8'h7F}};
    vecs[3] = '{8'd0, 8'h55, {8'h00, 8'h00, 8'h00}};

    reset = 1'b1; start = 0; full = 0; burst_len = 0; seed = 0;
    start2 = 0; full2 = 0; burst_len2 = 0; seed2 = 0;
    #23 reset = 1'b0;
    step(); step();
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_words", {24'd0, words_written}, 0);
    chk("rst_stall", {24'd0, stall_cycles}, 0);

    // Table-driven unstalled bursts
    foreach (vecs[v]) begin
      start = 1; burst_len = vecs[v].len; seed = vecs[v].sd;
      step();
      start = 0;
      if (vecs[v].len == 0) begin
        chk("zl_done", {31'd0, done}, 1);
        chk("zl_busy", {31'd0, busy}, 0);
        chk("zl_words", {24'd0, words_written}, 0);
        chk("zl_wr_en", {31'd0, wr_en}, 0);
        step();
        chk("zl_done_clr", {31'd0, done}, 0);
        chk("zl_busy2", {31'd0, busy}, 0);
      end else begin
        chk("vec_busy", {31'd0, busy}, 1);
        chk("vec_words0", {24'd0, words_written}, 0);
        for (int k = 1; k <= vecs[v].len * DIV; k++) begin
          step();
          chk("vec_wr_en", {31'd0, wr_en}, (k % DIV == 0) ? 1 : 0);
          if (k % DIV == 0) chk("vec_wr_data", {24'd0, wr_data}, {24'd0, vecs[v].d[k / DIV - 1]});
          chk("vec_done_early", {31'd0, done}, 0);
        end
        step();
        chk("vec_done", {31'd0, done}, 1);
        chk("vec_busy_fall", {31'd0, busy}, 0);
        chk("vec_words", {24'd0, words_written}, {24'd0, vecs[v].len});
        step();
        chk("vec_done_clr", {31'd0, done}, 0);
        chk("vec_words_hold", {24'd0, words_written}, {24'd0, vecs[v].len});
      end
    end

    // Full stall: full high for edges E0+10..E0+29
    start = 1; burst_len = 2; seed = 8'h20;
    step();
    start = 0;
    for (int k = 1; k <= 48; k++) begin
      full = (k >= 10 && k <= 29);
      step();
      chk("stall_wr_en", {31'd0, wr_en}, (k == 30 || k == 48) ? 1 : 0);
      if (k == 30) chk("stall_d0", {24'd0, wr_data}, 32'h20);
      if (k == 48) chk("stall_d1", {24'd0, wr_data}, 32'h21);
    end
    full = 0;
    step();
    chk("stall_done", {31'd0, done}, 1);
    chk("stall_cycles", {24'd0, stall_cycles}, 12);
    chk("stall_words", {24'd0, words_written}, 2);
    step();

    // start while busy and during FINISH is ignored
    start = 1; burst_len = 3; seed = 8'h40;
    step();
    start = 0;
    for (int k = 1; k <= 54; k++) begin
      start = (k == 5 || k == 20);
      burst_len = 8'd7; seed = 8'h99;
      step();
      start = 0;
      chk("ign_wr_en", {31'd0, wr_en}, (k % DIV == 0) ? 1 : 0);
      if (k == 20) chk("ign_words_kept", {24'd0, words_written}, 1);
      if (k == 54) chk("ign_last_data", {24'd0, wr_data}, 32'h42);
    end
    start = 1; burst_len = 8'd5; seed = 8'h77;
    step();
    start = 0;
    chk("ign_done", {31'd0, done}, 1);
    chk("ign_busy_fall", {31'd0, busy}, 0);
    chk("ign_words", {24'd0, words_written}, 3);
    step();
    chk("ign_fin_busy", {31'd0, busy}, 0);
    chk("ign_fin_done", {31'd0, done}, 0);
    step();
    chk("ign_fin_wr_en", {31'd0, wr_en}, 0);

    // Reset mid-burst right after the second write
    start = 1; burst_len = 5; seed = 8'h30;
    step();
    start = 0;
    for (int k = 1; k <= 36; k++) step();
    chk("rm_wr_en_before", {31'd0, wr_en}, 1);
    #1 reset = 1'b1;
    #1;
    chk("rm_wr_en", {31'd0, wr_en}, 0);
    chk("rm_busy", {31'd0, busy}, 0);
    chk("rm_words", {24'd0, words_written}, 0);
    chk("rm_data", {24'd0, wr_data}, 0);
    #2 reset = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (done || wr_en || busy) saw_done = 1;
    end
    chk("rm_no_activity", {31'd0, saw_done}, 0);

    // Saturating stall counter (CNT_W=4): full high for edges E0+18..E0+57
    start2 = 1; burst_len2 = 2; seed2 = 8'h05;
    step();
    start2 = 0;
    for (int k = 1; k <= 76; k++) begin
      full2 = (k >= 18 && k <= 57);
      step();
      chk("sat_wr_en", {31'd0, wr_en2}, (k == 58 || k == 76) ? 1 : 0);
      if (k == 58) chk("sat_d0", {24'd0, wr_data2}, 32'h05);
      if (k == 40) chk("sat_mid", {28'd0, stall_cycles2}, 15);
    end
    full2 = 0;
    step();
    chk("sat_done", {31'd0, done2}, 1);
    chk("sat_stall", {28'd0, stall_cycles2}, 15);
    chk("sat_words", {28'd0, words_written2}, 2);
    chk("sat_last_data", {24'd0, wr_data2}, 32'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
